softmax_inp_buffer: RTL

Upstream input stage for the softmax block. Accepts a stream of packed NUM-lane fp16 words over a valid/ready handshake and stores them in a local register array. When the vector is complete it drives addr_limit and pulses start_max. During the softmax run it serves the three independent read ports (inp, sub0_inp, sub1_inp) at the addresses the softmax block requests.

---
 rtl/softmax_inp_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/softmax_inp_buffer.sv
// softmax_inp_buffer
//   Upstream input stage for the softmax block. Collects a vector of packed
//   NUM-lane fp16 words over a valid/ready handshake into a local register
//   array, publishes the index of the last stored word on addr_limit, pulses
//   start_max, then serves three independent asynchronous read ports while
//   softmax runs.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready   input stream handshake
//   addr, sub0_inp_addr, sub1_inp_addr  read addresses (ports 0..2)
//   inp, sub0_inp, sub1_inp             combinational read data (ports 0..2)
//   addr_limit          index of the last stored word
//   start_max           one-cycle start pulse to softmax
//   softmax_done        softmax finished the current vector
//   busy                high while a vector is being processed (START/RUN)
//   overflow            sticky: vector truncated at DEPTH words
module softmax_inp_buffer #(
    parameter int DATAWIDTH = 16,
    parameter int NUM       = 4,
    parameter int ADDRSIZE  = 8,
    parameter int DEPTH     = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATAWIDTH*NUM-1:0]  in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    input  logic [ADDRSIZE-1:0]       addr,
    input  logic [ADDRSIZE-1:0]       sub0_inp_addr,
    input  logic [ADDRSIZE-1:0]       sub1_inp_addr,
    output logic [DATAWIDTH*NUM-1:0]  inp,
    output logic [DATAWIDTH*NUM-1:0]  sub0_inp,
    output logic [DATAWIDTH*NUM-1:0]  sub1_inp,
    output logic [ADDRSIZE-1:0]       addr_limit,
    output logic                      start_max,
    input  logic                      softmax_done,
    output logic                      busy,
    output logic                      overflow
);

    localparam int WW = DATAWIDTH * NUM;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRSIZE-1:0] LAST_IDX = ADDRSIZE'(DEPTH - 1);
    localparam logic [ADDRSIZE:0]   DEPTH_W  = (ADDRSIZE + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_t;

    state_t              state;
    logic [ADDRSIZE-1:0] wr_ptr;
    logic [WW-1:0]       mem [DEPTH];

    logic accept;
    logic beat_final;

    assign accept     = in_valid && in_ready;
    // A beat landing in the last slot closes the vector even without in_last.
    assign beat_final = in_last || (wr_ptr == LAST_IDX);

    // Storage is never cleared; a beat coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            mem[wr_ptr[IW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            start_max  <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            addr_limit <= '0;
            wr_ptr     <= '0;
        end else begin
            start_max <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (accept) begin
                        if (state == IDLE) begin
                            overflow <= 1'b0;
                        end
                        if (beat_final) begin
                            addr_limit <= wr_ptr;
                            overflow   <= !in_last;
                            state      <= START;
                            in_ready   <= 1'b0;
                            busy       <= 1'b1;
                            start_max  <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            state  <= LOAD;
                        end
                    end
                end
                START: begin
                    wr_ptr   <= '0;
                    state    <= RUN;
                    busy     <= 1'b1;
                    in_ready <= 1'b0;
                end
                RUN: begin
                    if (softmax_done) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range addresses (beyond addr_limit or storage) read as zero.
    function automatic logic [WW-1:0] read_port(input logic [ADDRSIZE-1:0] a);
        if ((a <= addr_limit) && ({1'b0, a} < DEPTH_W)) begin
            return mem[a[IW-1:0]];
        end
        return '0;
    endfunction

    assign inp      = read_port(addr);
    assign sub0_inp = read_port(sub0_inp_addr);
    assign sub1_inp = read_port(sub1_inp_addr);

endmodule
